reg_burst_sink: RTL and testbench

- Downstream consumer of the register-number sequencer. That sequencer emits a 5-step regnum burst: 8, then 9..12 (up) or 7..4 (down), then asserts done.
- This block writes wr_data into an internal 32-entry register file at each regnum of the burst.
- It counts the writes, checks that the addresses are contiguous, and flags completion or error.
- It exposes a combinational read port for downstream datapath and debug.

---
 rtl/reg_burst_sink.sv | 172 +++++++++++++++++
 tb/tb_reg_burst_sink.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_burst_sink.sv
// -----------------------------------------------------------------------------
// reg_burst_sink
//
// Consumes the regnum burst produced by the register-number sequencer and
// writes wr_data into a 32-entry register file at each step. It counts the
// writes, checks that the burst addresses step contiguously in one direction
// (modulo 32), and reports completion or error. A combinational read port
// gives downstream logic and debug access to the register file.
//
// Ports:
//   clock       in   rising-edge system clock
//   reset       in   asynchronous, active-low reset
//   go          in   sequencer go (arms / aborts a burst)
//   done        in   sequencer done (ends a burst)
//   regnum      in   write address for the current burst step
//   wr_data     in   write data for the current burst step
//   rd_addr     in   read address
//   rd_data     out  regs[rd_addr], combinational; 0 for address 0
//   burst_done  out  high while the burst is complete
//   burst_err   out  sticky error for the current or last burst
//   wr_count    out  writes in the current or last burst (saturates at 15)
//   last_reg    out  address of the most recent write
// -----------------------------------------------------------------------------
module reg_burst_sink #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             done,
    input  logic [4:0]       regnum,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             burst_done,
    output logic             burst_err,
    output logic [3:0]       wr_count,
    output logic [4:0]       last_reg
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_WRITING,
        S_COMPLETE
    } state_t;

    localparam logic [3:0] MAX_CNT   = 4'(MAX_BURST);
    localparam logic [3:0] BURST_LEN = 4'd5;

    state_t           state_q, state_d;
    logic [3:0]       wr_count_q, wr_count_d;
    logic             burst_err_q, burst_err_d;
    logic [4:0]       last_reg_q, last_reg_d;
    // Direction of the current burst, fixed by its second write.
    logic             dir_valid_q, dir_valid_d;
    logic             dir_up_q, dir_up_d;
    logic             wr_en;
    logic [WIDTH-1:0] regs_q [32];

    logic [3:0] cnt_inc;
    logic [4:0] addr_up, addr_down;

    assign cnt_inc   = (wr_count_q == 4'd15) ? 4'd15 : wr_count_q + 4'd1;
    assign addr_up   = last_reg_q + 5'd1;   // 5-bit wrap: 31+1 = 0
    assign addr_down = last_reg_q - 5'd1;

    // NOTE: every signal written here is given a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        burst_err_d = burst_err_q;
        last_reg_d  = last_reg_q;
        dir_valid_d = dir_valid_q;
        dir_up_d    = dir_up_q;
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE, S_COMPLETE: begin
                if (go) begin
                    state_d     = S_ARMED;
                    wr_count_d  = 4'd0;
                    burst_err_d = 1'b0;
                end
            end

            S_ARMED: begin
                // First write of the burst happens on the edge go drops.
                if (!go) begin
                    wr_en       = 1'b1;
                    wr_count_d  = 4'd1;
                    last_reg_d  = regnum;
                    dir_valid_d = 1'b0;
                    state_d     = S_WRITING;
                end
            end

            S_WRITING: begin
                if (go) begin
                    burst_err_d = 1'b1;
                    wr_count_d  = 4'd0;
                    state_d     = S_ARMED;
                end else if (done) begin
                    if (wr_count_q != BURST_LEN) burst_err_d = 1'b1;
                    state_d = S_COMPLETE;
                end else if (wr_count_q >= MAX_CNT) begin
                    // Runaway burst: stop writing and close it as an error.
                    burst_err_d = 1'b1;
                    state_d     = S_COMPLETE;
                end else begin
                    wr_en      = 1'b1;
                    wr_count_d = cnt_inc;
                    last_reg_d = regnum;
                    if (!dir_valid_q) begin
                        dir_valid_d = 1'b1;
                        if (regnum == addr_up) begin
                            dir_up_d = 1'b1;
                        end else if (regnum == addr_down) begin
                            dir_up_d = 1'b0;
                        end else begin
                            burst_err_d = 1'b1;
                        end
                    end else if (regnum != (dir_up_q ? addr_up : addr_down)) begin
                        burst_err_d = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_count_q  <= 4'd0;
            burst_err_q <= 1'b0;
            last_reg_q  <= 5'd0;
            dir_valid_q <= 1'b0;
            dir_up_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            burst_err_q <= burst_err_d;
            last_reg_q  <= last_reg_d;
            dir_valid_q <= dir_valid_d;
            dir_up_q    <= dir_up_d;
        end
    end

    // NOTE: the register file is reset because its contents are architecturally
    // visible as zero after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_en && (regnum != 5'd0)) begin
            // Writes to address 0 are dropped (still counted above).
            regs_q[regnum] <= wr_data;
        end
    end

    assign rd_data    = (rd_addr == 5'd0) ? '0 : regs_q[rd_addr];
    assign burst_done = (state_q == S_COMPLETE);
    assign burst_err  = burst_err_q;
    assign wr_count   = wr_count_q;
    assign last_reg   = last_reg_q;

endmodule

// File: tb/tb_reg_burst_sink.sv
// -----------------------------------------------------------------------------
// tb_reg_burst_sink
//
// Drives directed and random bursts into reg_burst_sink and compares its
// outputs against a burst-level reference model: the model takes the list of
// addresses/data of a burst and derives the expected register contents, write
// count, last address and error flag from the burst rules directly.
// -----------------------------------------------------------------------------
module tb_reg_burst_sink;

    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             go;
    logic             done;
    logic [4:0]       regnum;
    logic [WIDTH-1:0] wr_data;
    logic [4:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             burst_done;
    logic             burst_err;
    logic [3:0]       wr_count;
    logic [4:0]       last_reg;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WIDTH-1:0] mem_m [32];
    logic             err_m;
    logic [3:0]       cnt_m;
    logic [4:0]       last_m;

    // Burst description consumed by run_burst.
    logic [4:0]       addr_a [16];
    logic [WIDTH-1:0] data_a [16];

    reg_burst_sink #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
        .done       (done),
        .regnum     (regnum),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .burst_done (burst_done),
        .burst_err  (burst_err),
        .wr_count   (wr_count),
        .last_reg   (last_reg)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic exp_done);
        check({tag, "_done"},  32'(burst_done), 32'(exp_done));
        check({tag, "_err"},   32'(burst_err),  32'(err_m));
        check({tag, "_count"}, 32'(wr_count),   32'(cnt_m));
        check({tag, "_last"},  32'(last_reg),   32'(last_m));
    endtask

    // Reads every address; no writes can occur while go=0 outside a burst.
    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), rd_data, mem_m[i]);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        err_m  = 1'b0;
        cnt_m  = 4'd0;
        last_m = 5'd0;
    endtask

    // Runs go for two cycles, n burst steps, then a done pulse; then checks
    // the block against the burst-level model. keep_err: burst starts from
    // ARMED after an abort, so the error flag is not cleared by go.
    task automatic run_burst(input string tag, input int n, input bit keep_err);
        int         cnt;
        logic [4:0] step;
        logic [4:0] diff;
        go = 1'b1;
        tick();
        if (!keep_err) begin
            err_m = 1'b0;
            cnt_m = 4'd0;
        end
        check({tag, "_armed_done"},  32'(burst_done), 32'd0);
        check({tag, "_armed_err"},   32'(burst_err),  32'(err_m));
        check({tag, "_armed_count"}, 32'(wr_count),   32'(cnt_m));
        tick();
        go = 1'b0;
        for (int i = 0; i < n; i++) begin
            regnum  = addr_a[i];
            wr_data = data_a[i];
            tick();
        end
        done = 1'b1;
        tick();
        done   = 1'b0;
        regnum = 5'd0;

        cnt  = (n < MAX_BURST) ? n : MAX_BURST;
        step = 5'd0;
        for (int i = 0; i < cnt; i++) begin
            if (addr_a[i] != 5'd0) mem_m[addr_a[i]] = data_a[i];
            if (i >= 1) begin
                diff = addr_a[i] - addr_a[i-1];
                if (i == 1) begin
                    step = diff;
                    if (step != 5'd1 && step != 5'd31) err_m = 1'b1;
                end else if (diff != step) begin
                    err_m = 1'b1;
                end
            end
        end
        if (cnt != 5) err_m = 1'b1;
        cnt_m  = 4'(cnt);
        last_m = addr_a[cnt-1];

        check_status(tag, 1'b1);
        check_regs(tag);
    endtask

    task automatic set_linear(input logic [4:0] start, input logic [4:0] step,
                              input logic [31:0] dbase, input int n);
        logic [4:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            addr_a[i] = a;
            data_a[i] = dbase + 32'(i);
            a = a + step;
        end
    endtask

    initial begin
        reset   = 1'b0;
        go      = 1'b0;
        done    = 1'b0;
        regnum  = 5'd0;
        wr_data = '0;
        rd_addr = 5'd0;
        clear_model();

        // Reset state.
        tick();
        tick();
        check_status("reset", 1'b0);
        check_regs("reset");
        reset = 1'b1;
        tick();

        // Directed bursts.
        set_linear(5'd8, 5'd1, 32'hA0, 5);
        run_burst("up", 5, 1'b0);

        set_linear(5'd8, 5'd31, 32'h10, 5);
        run_burst("down", 5, 1'b0);

        set_linear(5'd8, 5'd1, 32'h20, 5);
        addr_a[2] = 5'd11; addr_a[3] = 5'd12; addr_a[4] = 5'd13;
        run_burst("noncontig", 5, 1'b0);

        set_linear(5'd8, 5'd1, 32'h30, 10);
        run_burst("runaway", 10, 1'b0);

        // Wrap through address 0: contiguous, and the write to 0 is dropped.
        set_linear(5'd31, 5'd1, 32'h40, 5);
        data_a[1] = 32'hFF;
        run_burst("reg0", 5, 1'b0);

        // Abort after two writes, with done raised on the same edge as go.
        go = 1'b1;
        tick();
        tick();
        go = 1'b0;
        regnum = 5'd8; wr_data = 32'h55; tick();
        regnum = 5'd9; wr_data = 32'h66; tick();
        go   = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        mem_m[8] = 32'h55;
        mem_m[9] = 32'h66;
        err_m    = 1'b1;
        cnt_m    = 4'd0;
        last_m   = 5'd9;
        check_status("abort", 1'b0);
        set_linear(5'd8, 5'd1, 32'h70, 5);
        run_burst("after_abort", 5, 1'b1);

        // Random bursts, some with a corrupted step.
        for (int k = 0; k < 20; k++) begin
            int         n;
            logic [4:0] start;
            logic [4:0] step;
            n     = int'($urandom_range(3, 10));
            start = 5'($urandom_range(0, 31));
            step  = ($urandom_range(0, 1) == 1) ? 5'd1 : 5'd31;
            set_linear(start, step, 32'h0, n);
            for (int i = 0; i < n; i++) data_a[i] = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                int j;
                j = int'($urandom_range(1, n - 1));
                addr_a[j] = addr_a[j] + 5'($urandom_range(2, 30));
            end
            run_burst($sformatf("rnd%0d", k), n, 1'b0);
        end

        // Asynchronous reset in the middle of a burst, between clock edges.
        go = 1'b1;
        tick();
        tick();
        go = 1'b0;
        regnum = 5'd8; wr_data = 32'hDEAD0008; tick();
        regnum = 5'd9; wr_data = 32'hDEAD0009; tick();
        #2;
        reset = 1'b0;
        #1;
        clear_model();
        rd_addr = 5'd8;
        #1;
        check("midrst_rd8", rd_data, 32'd0);
        check_status("midrst", 1'b0);
        tick();
        reset = 1'b1;
        // The in-flight sequencer burst continues and must be ignored.
        for (int i = 10; i <= 12; i++) begin
            regnum  = 5'(i);
            wr_data = 32'hBEEF0000 + 32'(i);
            tick();
        end
        done = 1'b1;
        tick();
        done   = 1'b0;
        regnum = 5'd0;
        check_status("postrst", 1'b0);
        check_regs("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
